// File: rtl/pdm_rx.sv
// pdm_rx: PDM microphone front end. Divides clk_i down to pdm_clk_o, captures
//   PDM data line 0 (and line 1 when PDM_RX_LINE1_EN is defined) on both clock
//   phases, and replays them as a 1-bit channel-interleaved strobe stream.
// Latency: pad to capture is 2 cycles (synchronizer). A burst of n+1 strobes
//   starts 1 cycle after each low-phase end.
// Backpressure: none. The consumer must take every data_valid_o strobe.
// Macro PDM_RX_LINE1_EN: when defined, line 1 is captured (ch2/ch3). Otherwise
//   ch2/ch3 read 0 and pdm_data_i[1] is ignored.
// Ports:
//   clk_i, rstn_i        system clock, async active-low reset
//   cfg_en_i             enable; low stops pdm_clk_o and clears all state
//                        except the synchronizers
//   cfg_ch_num_i         channels minus 1, latched at each buffer load
//   cfg_clk_div_i        PDM half-period minus 1 (clamped to >= 2)
//   pdm_clk_o            PDM clock to the microphones
//   pdm_data_i           asynchronous PDM data pads (line 0, line 1)
//   data_o/data_valid_o  interleaved channel bit and its strobe
module pdm_rx #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [1:0]           cfg_ch_num_i,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div_i,
    output logic                 pdm_clk_o,
    input  logic [1:0]           pdm_data_i,
    output logic                 data_o,
    output logic                 data_valid_o
);

    logic [1:0]           sync0_q;
    logic                 line0;
    logic [3:0]           load_val;

    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 phase_end;
    logic                 pdm_clk_q, pdm_clk_d;
    logic                 primed_q, primed_d;
    logic                 h0_q, h0_d;
    logic [3:0]           buf_q, buf_d;
    logic [1:0]           n_q, n_d;
    logic [1:0]           idx_q, idx_d;
    logic                 act_q, act_d;
    logic                 data_q, data_d;
    logic                 valid_q, valid_d;

    assign line0 = sync0_q[1];

    // Synchronizers free-run regardless of cfg_en_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync0_q <= '0;
        end else begin
            sync0_q <= {sync0_q[0], pdm_data_i[0]};
        end
    end

`ifdef PDM_RX_LINE1_EN
    logic [1:0] sync1_q;
    logic       line1;
    logic       h2_q, h2_d;

    assign line1 = sync1_q[1];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            h2_q    <= 1'b0;
        end else begin
            sync1_q <= {sync1_q[0], pdm_data_i[1]};
            h2_q    <= h2_d;
        end
    end

    always_comb begin
        h2_d = h2_q;
        if (!cfg_en_i) begin
            h2_d = 1'b0;
        end else if (phase_end && pdm_clk_q) begin
            h2_d = line1;
        end
    end

    // Bit k is channel k: {line1 low, line1 high, line0 low, line0 high}.
    assign load_val = {line1, h2_q, line0, h0_q};
`else
    logic unused_line1;
    assign unused_line1 = pdm_data_i[1];
    assign load_val     = {2'b00, line0, h0_q};
`endif

    assign div_eff   = (cfg_clk_div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_clk_div_i;
    // div_q is refreshed only at a wrap (or while idle), so a divider change
    // never shortens the half-period already in progress.
    assign phase_end = (cnt_q == div_q);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        pdm_clk_d = pdm_clk_q;
        primed_d  = primed_q;
        h0_d      = h0_q;
        buf_d     = buf_q;
        n_d       = n_q;
        idx_d     = idx_q;
        act_d     = act_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        if (!cfg_en_i) begin
            cnt_d     = '0;
            div_d     = div_eff;
            pdm_clk_d = 1'b0;
            primed_d  = 1'b0;
            h0_d      = 1'b0;
            buf_d     = '0;
            n_d       = '0;
            idx_d     = '0;
            act_d     = 1'b0;
            data_d    = 1'b0;
        end else begin
            if (act_q) begin
                valid_d = 1'b1;
                data_d  = buf_q[idx_q];
                idx_d   = idx_q + 2'd1;
                if (idx_q == n_q) begin
                    act_d = 1'b0;
                end
            end

            if (phase_end) begin
                cnt_d     = '0;
                div_d     = div_eff;
                pdm_clk_d = ~pdm_clk_q;
                if (pdm_clk_q) begin
                    h0_d     = line0;
                    primed_d = 1'b1;
                end else if (primed_q) begin
                    // Low-phase end with a high phase already held: start a burst.
                    buf_d = load_val;
                    n_d   = cfg_ch_num_i;
                    idx_d = '0;
                    act_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q     <= '0;
            div_q     <= DIV_WIDTH'(2);
            pdm_clk_q <= 1'b0;
            primed_q  <= 1'b0;
            h0_q      <= 1'b0;
            buf_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            act_q     <= 1'b0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            primed_q  <= primed_d;
            h0_q      <= h0_d;
            buf_q     <= buf_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            act_q     <= act_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign pdm_clk_o    = pdm_clk_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;

endmodule

// File: tb/tb_pdm_rx.sv
// tb_pdm_rx: randomized and directed bench for pdm_rx against a closed-form
//   timing model (wrap edges at d+m*(d+1) after enable, loads at even m >= 2).
// Latency/backpressure: not applicable (bench).
module tb_pdm_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] ch;
    logic [7:0] div;
    logic [1:0] pad;
    logic       pdm_clk;
    logic       dat;
    logic       vld;

    pdm_rx #(.DIV_WIDTH(8)) dut (
        .clk_i        (clk),
        .rstn_i       (rst_n),
        .cfg_en_i     (en),
        .cfg_ch_num_i (ch),
        .cfg_clk_div_i(div),
        .pdm_clk_o    (pdm_clk),
        .pdm_data_i   (pad),
        .data_o       (dat),
        .data_valid_o (vld)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Input history indexed by the clock edge that samples it.
    logic       en_h [0:16383];
    logic [1:0] ch_h [0:16383];
    logic       p0_h [0:16383];
    logic       p1_h [0:16383];
    int         dv_h [0:16383];

    int         run_e = -1;
    int         d_run = 2;
    bit         seen_rise, seen_vld;
    bit         follow = 1'b0;
    bit         pat_on = 1'b0;
    logic [3:0] pat = 4'b0;
    int         bpos = 0;
    int         last_blen = 0;
    bit         fell = 1'b0;

    task automatic chk(input string tag, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", tag, act, want, cyc);
        end
    endtask

    task automatic step();
        int t, m, ld, hi, k, n;
        logic [3:0] bits;
        bit e_clk, e_vld, e_dat;
        en_h[cyc+1] = en;
        ch_h[cyc+1] = ch;
        p0_h[cyc+1] = pad[0];
        p1_h[cyc+1] = pad[1];
        dv_h[cyc+1] = int'(div);
        @(posedge clk);
        cyc++;
        #1;
        e_clk = 1'b0; e_vld = 1'b0; e_dat = 1'b0;
        if (!en_h[cyc]) begin
            run_e = -1;
        end else begin
            if (run_e < 0) begin
                run_e     = cyc;
                d_run     = (dv_h[cyc] < 2) ? 2 : dv_h[cyc];
                seen_rise = 1'b0;
                seen_vld  = 1'b0;
            end
            t     = cyc - run_e;
            e_clk = (((t + 1) / (d_run + 1)) % 2) == 1;
            if (t - 1 >= d_run) begin
                m = (t - 1 - d_run) / (d_run + 1);
                if (m % 2 == 1) m--;
                if (m >= 2) begin
                    ld = d_run + m * (d_run + 1);
                    hi = ld - (d_run + 1);
                    k  = t - ld;
                    n  = int'(ch_h[run_e + ld]);
                    bits[0] = p0_h[run_e + hi - 2];
                    bits[1] = p0_h[run_e + ld - 2];
`ifdef PDM_RX_LINE1_EN
                    bits[2] = p1_h[run_e + hi - 2];
                    bits[3] = p1_h[run_e + ld - 2];
`else
                    bits[3:2] = 2'b00;
`endif
                    if (k >= 1 && k <= n + 1) begin
                        e_vld = 1'b1;
                        e_dat = bits[k-1];
                    end
                end
            end
            if (!seen_rise && pdm_clk) begin
                seen_rise = 1'b1;
                chk("first_rise", t, d_run);
            end
            if (!seen_vld && vld) begin
                seen_vld = 1'b1;
                chk("first_valid", t, 3 * d_run + 3);
            end
        end
        chk("pdm_clk", int'(pdm_clk), int'(e_clk));
        chk("valid", int'(vld), int'(e_vld));
        if (e_vld) chk("data", int'(dat), int'(e_dat));

        fell = 1'b0;
        if (vld) begin
            if (pat_on && bpos < 4) chk("pattern", int'(dat), int'(pat[bpos]));
            bpos++;
        end else begin
            if (bpos != 0) begin
                last_blen = bpos;
                fell      = 1'b1;
            end
            bpos = 0;
        end
        if (follow) pad[0] = pdm_clk;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_strobe(input int nth);
        for (int i = 0; i < 200; i++) begin
            step();
            if (vld && bpos == nth) return;
        end
        chk("timeout_strobe", 0, 1);
    endtask

    task automatic wait_burst_end(output int len);
        len = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (fell) begin
                len = last_blen;
                return;
            end
        end
        chk("timeout_burst", 0, 1);
    endtask

    initial begin
        int len;
        rst_n = 1'b0; en = 1'b0; ch = 2'd1; div = 8'd4; pad = 2'b00;
        steps(3);
        chk("rst_data", int'(dat), 0);
        chk("rst_valid", int'(vld), 0);
        chk("rst_pdm_clk", int'(pdm_clk), 0);
        rst_n = 1'b1;
        steps(3);

        // Line 0 follows pdm_clk: high phase reads 1, low phase 0.
        div = 8'd4; ch = 2'd1; follow = 1'b1; pat = 4'b0001; pat_on = 1'b1;
        en = 1'b1;
        steps(60);
        pat_on = 1'b0; follow = 1'b0; en = 1'b0;
        steps(3);

        // Line 0 = 0, line 1 = 1, four channels.
        ch = 2'd3; pad = 2'b10;
`ifdef PDM_RX_LINE1_EN
        pat = 4'b1100;
`else
        pat = 4'b0000;
`endif
        pat_on = 1'b1; en = 1'b1;
        steps(60);
        pat_on = 1'b0; en = 1'b0;
        steps(3);

        // div=0 clamps to 2; drop enable on 2nd strobe, then re-enable.
        div = 8'd0; ch = 2'd3;
        steps(2);
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pad = 2'($urandom);
            step();
        end
        wait_strobe(2);
        en = 1'b0;
        step();
        chk("drop_pdm_clk", int'(pdm_clk), 0);
        chk("drop_valid", int'(vld), 0);
        steps(3);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pad = 2'($urandom);
            step();
        end
        en = 1'b0;

        // ch_num 3 -> 0 mid-burst.
        div = 8'd3; ch = 2'd3;
        steps(2);
        en = 1'b1;
        wait_strobe(1);
        ch = 2'd0;
        wait_burst_end(len);
        chk("burst_len_cur", len, 4);
        wait_burst_end(len);
        chk("burst_len_next", len, 1);
        en = 1'b0;
        steps(2);

        // Randomized runs.
        for (int r = 0; r < 30; r++) begin
            int gap, run_len;
            en  = 1'b0;
            div = 8'($urandom_range(0, 6));
            gap = $urandom_range(1, 4);
            for (int i = 0; i < gap; i++) begin
                pad = 2'($urandom);
                step();
            end
            ch      = 2'($urandom_range(0, 3));
            run_len = $urandom_range(30, 120);
            en      = 1'b1;
            for (int i = 0; i < run_len; i++) begin
                pad = 2'($urandom);
                if ($urandom_range(0, 15) == 0) ch = 2'($urandom_range(0, 3));
                step();
            end
        end
        en = 1'b0;
        steps(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
